// File: rtl/dma_mem_arb_pkg.sv
// Shared constants and types for the DMA / CPU memory arbiter.
package dma_mem_arb_pkg;

    // Physical byte address width, shared with the RK05 register block.
    localparam int DMA_ADDR_W = 18;
    localparam int DATA_W     = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_e;

    // Qualified memory operation latched when a requester is granted.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } arb_op_e;

    // Write wins when both strobes are set; neither strobe gives a no-op cycle.
    function automatic arb_op_e qualify_op(input logic rd, input logic wr);
        if (wr) begin
            return OP_WR;
        end
        if (rd) begin
            return OP_RD;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/dma_mem_arb.sv
// Memory-side arbiter: interleaves CPU cycles with RK05 DMA word transfers
// on a single RAM port, limiting DMA bursts when the CPU is waiting.
module dma_mem_arb
    import dma_mem_arb_pkg::*;
#(
    parameter int DMA_BURST = 8,
    parameter int ADDR_W    = DMA_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_rd,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_data_out,
    output logic [DATA_W-1:0] dma_data_in,
    output logic              dma_ack,
    output logic [ADDR_W-2:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    localparam int               CNT_W     = $clog2(DMA_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(DMA_BURST);

    arb_state_e        state_q, state_d;
    arb_op_e           op_q, op_d;
    logic              owner_dma_q, owner_dma_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              dma_win;
    logic              in_ram_cyc;
    logic              unused_addr_lsb;

    // Word transfers only: the byte-select bit of both addresses is dropped.
    assign unused_addr_lsb = cpu_addr[0] ^ dma_addr[0];

    // DMA has priority unless it has used up its burst while the CPU waits.
    assign dma_win = dma_req && !(cpu_req && (burst_cnt_q == BURST_MAX));

    // Next-state logic: grant, RAM handshake, completion pulse and burst accounting.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        owner_dma_d = owner_dma_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (!dma_req) begin
                    burst_cnt_d = '0;
                end
                if (dma_win) begin
                    owner_dma_d = 1'b1;
                    op_d        = qualify_op(dma_rd, dma_wr);
                    addr_d      = dma_addr[ADDR_W-1:1];
                    wdata_d     = dma_data_out;
                    state_d     = (op_d == OP_NONE) ? ARB_DONE : ARB_DMA;
                end else if (cpu_req) begin
                    owner_dma_d = 1'b0;
                    op_d        = qualify_op(cpu_rd, cpu_wr);
                    addr_d      = cpu_addr[ADDR_W-1:1];
                    wdata_d     = cpu_wdata;
                    state_d     = (op_d == OP_NONE) ? ARB_DONE : ARB_CPU;
                end
            end
            ARB_CPU, ARB_DMA: begin
                if (ram_ready) begin
                    if (op_q == OP_RD) begin
                        rdata_d = ram_rdata;
                    end
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
                if (owner_dma_q) begin
                    if (burst_cnt_q != BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end else begin
                    burst_cnt_d = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any cycle in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            op_q        <= OP_NONE;
            owner_dma_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            owner_dma_q <= owner_dma_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign in_ram_cyc  = (state_q == ARB_CPU) || (state_q == ARB_DMA);
    assign ram_rd      = in_ram_cyc && (op_q == OP_RD);
    assign ram_wr      = in_ram_cyc && (op_q == OP_WR);
    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign cpu_done    = (state_q == ARB_DONE) && !owner_dma_q;
    assign dma_ack     = (state_q == ARB_DONE) && owner_dma_q;
    assign cpu_rdata   = rdata_q;
    assign dma_data_in = rdata_q;
    assign cpu_stall   = dma_req || (state_q == ARB_DMA) ||
                         ((state_q == ARB_DONE) && owner_dma_q);

endmodule

// File: tb/tb_dma_mem_arb.sv
// Self-checking bench for dma_mem_arb: directed scenarios plus randomized
// single transfers checked against a word-addressed reference memory.
module tb_dma_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_rd, cpu_wr;
    logic [17:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_stall;
    logic        dma_req, dma_rd, dma_wr;
    logic [17:0] dma_addr;
    logic [15:0] dma_data_out, dma_data_in;
    logic        dma_ack;
    logic [16:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        ram_rd, ram_wr, ram_ready;

    int tests_run = 0;
    int fails     = 0;

    // RAM model state: extra wait cycles beyond the minimum one-cycle response.
    int          ram_delay = 0;
    logic [15:0] mem[int];
    logic [15:0] ref_mem[int];
    int          strobe_total   = 0;
    int          glitch_total   = 0;
    int          dma_ack_total  = 0;
    int          cpu_done_total = 0;
    logic [16:0] last_addr  = '0;
    logic        last_wr    = 1'b0;
    logic [15:0] last_wdata = '0;

    dma_mem_arb dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_rd(dma_rd), .dma_wr(dma_wr),
        .dma_addr(dma_addr), .dma_data_out(dma_data_out), .dma_data_in(dma_data_in),
        .dma_ack(dma_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int w);
        return 16'(w) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_read(input int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_word(w);
    endfunction

    function automatic logic [15:0] ram_read(input int w);
        if (mem.exists(w)) return mem[w];
        return init_word(w);
    endfunction

    // RAM responder and bus monitor, both evaluated on the falling edge.
    initial begin
        int          wait_cnt = 0;
        logic        in_strobe = 1'b0;
        logic [16:0] held_addr = '0;
        ram_ready = 1'b0;
        ram_rdata = '0;
        forever begin
            @(negedge clk);
            if (dma_ack === 1'b1)  dma_ack_total++;
            if (cpu_done === 1'b1) cpu_done_total++;
            if (ram_rd === 1'b1 || ram_wr === 1'b1) begin
                strobe_total++;
                if (in_strobe && ram_addr !== held_addr) glitch_total++;
                if (ram_rd === 1'b1 && ram_wr === 1'b1) glitch_total++;
                in_strobe  = 1'b1;
                held_addr  = ram_addr;
                last_addr  = ram_addr;
                last_wr    = ram_wr;
                last_wdata = ram_wdata;
                if (wait_cnt == ram_delay + 1) begin
                    ram_ready = 1'b1;
                    if (ram_wr === 1'b1) mem[int'(ram_addr)] = ram_wdata;
                    else ram_rdata = ram_read(int'(ram_addr));
                    wait_cnt = 0;
                end else begin
                    ram_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                in_strobe = 1'b0;
                ram_ready = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // One complete transfer from an idle arbiter; latency counted from the request cycle.
    task automatic do_xfer(input bit is_dma, input bit rd, input bit wr,
                           input logic [17:0] addr, input logic [15:0] wdata,
                           output logic [15:0] rdata, output int lat,
                           output int strobes, output int acks, output int glitches);
        int s0, g0, a0;
        bit got;
        @(negedge clk);
        s0 = strobe_total;
        g0 = glitch_total;
        a0 = is_dma ? dma_ack_total : cpu_done_total;
        if (is_dma) begin
            dma_req = 1'b1; dma_rd = rd; dma_wr = wr; dma_addr = addr; dma_data_out = wdata;
        end else begin
            cpu_req = 1'b1; cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        end
        lat = 0; got = 1'b0; rdata = '0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (is_dma ? (dma_ack === 1'b1) : (cpu_done === 1'b1)) begin
                got = 1'b1;
                rdata = is_dma ? dma_data_in : cpu_rdata;
            end
        end
        dma_req = 1'b0;
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        strobes  = strobe_total - s0;
        glitches = glitch_total - g0;
        acks     = (is_dma ? dma_ack_total : cpu_done_total) - a0;
        tests_run++;
        if (!got) begin
            fails++;
            $display("FAIL xfer_timeout: got no completion after %0d cycles, required one", lat);
        end
        $display("[TB] %s %s%s addr=%o wdata=%h rdata=%h lat=%0d strobes=%0d",
                 is_dma ? "dma" : "cpu", rd ? "r" : "-", wr ? "w" : "-",
                 addr, wdata, rdata, lat, strobes);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cpu_req = 0; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_rd = 0; dma_wr = 0; dma_addr = '0; dma_data_out = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({cpu_done, cpu_stall, dma_ack, ram_rd, ram_wr} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {cpu_done, cpu_stall, dma_ack, ram_rd, ram_wr});
        end
        tests_run++;
        if ({cpu_rdata, dma_data_in, ram_wdata, ram_addr} !== 65'b0) begin
            fails++;
            $display("FAIL reset_data: got %h %h %h %h, required all zero",
                     cpu_rdata, dma_data_in, ram_wdata, ram_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset done");
    endtask

    task automatic test_dma_read;
        logic [15:0] rd; int lat, st, ak, gl;
        ram_delay = 0;
        mem[int'(17'o400)] = 16'o123456;
        ref_mem[int'(17'o400)] = 16'o123456;
        do_xfer(1'b1, 1'b1, 1'b0, 18'o1000, 16'h0, rd, lat, st, ak, gl);
        tests_run++;
        if (last_addr !== 17'o400) begin fails++; $display("FAIL dma_rd_addr: got %o, required 400", last_addr); end
        tests_run++;
        if (rd !== 16'o123456) begin fails++; $display("FAIL dma_rd_data: got %o, required 123456", rd); end
        tests_run++;
        if (ak !== 1) begin fails++; $display("FAIL dma_rd_acks: got %0d, required 1", ak); end
        tests_run++;
        if (lat !== 3) begin fails++; $display("FAIL dma_rd_latency: got %0d, required 3", lat); end
    endtask

    task automatic test_dma_write;
        logic [15:0] rd; int lat, st, ak, gl;
        ram_delay = 2;
        do_xfer(1'b1, 1'b0, 1'b1, 18'o2, 16'hfe00, rd, lat, st, ak, gl);
        ref_mem[1] = 16'hfe00;
        tests_run++;
        if (ram_read(1) !== 16'hfe00) begin fails++; $display("FAIL dma_wr_mem: got %h, required fe00", ram_read(1)); end
        tests_run++;
        if (st !== 4 || last_wr !== 1'b1 || gl !== 0) begin
            fails++; $display("FAIL dma_wr_strobe: got cycles=%0d wr=%b glitches=%0d, required 4 1 0", st, last_wr, gl);
        end
        tests_run++;
        if (ak !== 1 || lat !== 5) begin fails++; $display("FAIL dma_wr_ack: got acks=%0d lat=%0d, required 1 5", ak, lat); end
    endtask

    task automatic test_contention;
        int acks = 0, dones = 0, since = 0, cyc = 0;
        ram_delay = 0;
        @(negedge clk);
        cpu_req = 1; cpu_rd = 1; cpu_wr = 0; cpu_addr = 18'($urandom_range(0, 4095));
        dma_req = 1; dma_rd = 1; dma_wr = 0; dma_addr = 18'($urandom_range(0, 4095));
        while ((acks < 256 || dones < 32) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (dma_ack === 1'b1) begin
                tests_run++;
                if (dma_data_in !== ref_read(int'(dma_addr[17:1]))) begin
                    fails++; $display("FAIL cont_dma_data: got %h, required %h", dma_data_in, ref_read(int'(dma_addr[17:1])));
                end
                acks++; since++;
                if (acks == 256) dma_req = 0;
                else dma_addr = 18'($urandom_range(0, 4095));
            end
            if (cpu_done === 1'b1) begin
                tests_run++;
                if (since !== 8 || cpu_rdata !== ref_read(int'(cpu_addr[17:1]))) begin
                    fails++; $display("FAIL cont_cpu_slot: got %0d acks data=%h, required 8 acks data=%h",
                                      since, cpu_rdata, ref_read(int'(cpu_addr[17:1])));
                end
                $display("[TB] contention cpu_done #%0d after %0d dma acks", dones + 1, since);
                dones++; since = 0;
                if (dones == 32) cpu_req = 0;
                else cpu_addr = 18'($urandom_range(0, 4095));
            end
        end
        dma_req = 0; cpu_req = 0;
        tests_run++;
        if (acks !== 256 || dones !== 32) begin
            fails++; $display("FAIL cont_totals: got acks=%0d dones=%0d, required 256 32", acks, dones);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_simultaneous;
        int cyc = 0;
        bit got = 0;
        logic [15:0] rd; int lat, st, ak, gl;
        ram_delay = 1;
        @(negedge clk);
        dma_req = 1; dma_rd = 0; dma_wr = 1; dma_addr = 18'o40; dma_data_out = 16'h1234;
        cpu_req = 1; cpu_rd = 1; cpu_wr = 0; cpu_addr = 18'o100;
        while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            tests_run++;
            if (cpu_stall !== 1'b1 || cpu_done !== 1'b0) begin
                fails++; $display("FAIL sim_stall: cycle %0d got stall=%b done=%b, required 1 0", cyc, cpu_stall, cpu_done);
            end
            if (dma_ack === 1'b1) begin got = 1; dma_req = 0; end
        end
        ref_mem[int'(17'o20)] = 16'h1234;
        got = 0; cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (cpu_done === 1'b1) begin
                got = 1;
                tests_run++;
                if (cpu_rdata !== ref_read(int'(17'o40))) begin
                    fails++; $display("FAIL sim_cpu_data: got %h, required %h", cpu_rdata, ref_read(int'(17'o40)));
                end
            end
        end
        cpu_req = 0;
        tests_run++;
        if (!got) begin fails++; $display("FAIL sim_cpu_done: got none in 50 cycles, required one"); end
        $display("[TB] simultaneous dma-first then cpu");
        do_xfer(1'b0, 1'b1, 1'b0, 18'o40, 16'h0, rd, lat, st, ak, gl);
        tests_run++;
        if (rd !== 16'h1234) begin fails++; $display("FAIL sim_readback: got %h, required 1234", rd); end
    endtask

    task automatic test_ram_delay;
        logic [15:0] rd; int lat, st, ak, gl;
        ram_delay = 5;
        do_xfer(1'b1, 1'b1, 1'b0, 18'o2000, 16'h0, rd, lat, st, ak, gl);
        tests_run++;
        if (lat !== 8 || ak !== 1) begin fails++; $display("FAIL delay_ack: got lat=%0d acks=%0d, required 8 1", lat, ak); end
        tests_run++;
        if (st !== 7 || gl !== 0) begin fails++; $display("FAIL delay_strobe: got cycles=%0d glitches=%0d, required 7 0", st, gl); end
        tests_run++;
        if (rd !== ref_read(int'(17'o1000))) begin fails++; $display("FAIL delay_data: got %h, required %h", rd, ref_read(int'(17'o1000))); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rd; int lat, st, ak, gl, a0;
        ram_delay = 5;
        @(negedge clk);
        a0 = dma_ack_total;
        dma_req = 1; dma_rd = 1; dma_wr = 0; dma_addr = 18'o3000;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ram_rd !== 1'b1) begin fails++; $display("FAIL rstmid_pre: got ram_rd=%b, required 1", ram_rd); end
        reset = 1; dma_req = 0;
        @(negedge clk);
        tests_run++;
        if ({ram_rd, ram_wr, dma_ack, cpu_stall} !== 4'b0) begin
            fails++; $display("FAIL rstmid_post: got %b, required 0000", {ram_rd, ram_wr, dma_ack, cpu_stall});
        end
        reset = 0;
        @(negedge clk);
        tests_run++;
        if (dma_ack_total !== a0) begin fails++; $display("FAIL rstmid_noack: got %0d acks, required 0", dma_ack_total - a0); end
        $display("[TB] reset during dma cycle");
        do_xfer(1'b1, 1'b1, 1'b0, 18'o3000, 16'h0, rd, lat, st, ak, gl);
        tests_run++;
        if (lat !== 8 || ak !== 1 || rd !== ref_read(int'(17'o1400))) begin
            fails++; $display("FAIL rstmid_reissue: got lat=%0d acks=%0d data=%h, required 8 1 %h",
                              lat, ak, rd, ref_read(int'(17'o1400)));
        end
    endtask

    task automatic test_illegal_and_addr;
        logic [15:0] rd; int lat, st, ak, gl;
        ram_delay = 0;
        do_xfer(1'b1, 1'b0, 1'b0, 18'o500, 16'h0, rd, lat, st, ak, gl);
        tests_run++;
        if (lat !== 1 || st !== 0 || ak !== 1) begin
            fails++; $display("FAIL illegal_none: got lat=%0d strobes=%0d acks=%0d, required 1 0 1", lat, st, ak);
        end
        do_xfer(1'b0, 1'b1, 1'b1, 18'o600, 16'hbeef, rd, lat, st, ak, gl);
        ref_mem[int'(17'o300)] = 16'hbeef;
        tests_run++;
        if (last_wr !== 1'b1 || ram_read(int'(17'o300)) !== 16'hbeef || ak !== 1) begin
            fails++; $display("FAIL illegal_both: got wr=%b mem=%h acks=%0d, required 1 beef 1",
                              last_wr, ram_read(int'(17'o300)), ak);
        end
        do_xfer(1'b1, 1'b1, 1'b0, 18'o777776, 16'h0, rd, lat, st, ak, gl);
        tests_run++;
        if (last_addr !== 17'h1FFFF || rd !== ref_read(int'(17'h1FFFF))) begin
            fails++; $display("FAIL addr_top: got addr=%h data=%h, required 1ffff %h",
                              last_addr, rd, ref_read(int'(17'h1FFFF)));
        end
    endtask

    task automatic test_random;
        logic [15:0] rd, wd; logic [17:0] a; int lat, st, ak, gl, d, w;
        bit is_dma, r, wr;
        for (int i = 0; i < 40; i++) begin
            is_dma = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = 18'(2 * $urandom_range(0, 15) + $urandom_range(0, 1));
            wd = 16'($urandom);
            d  = $urandom_range(0, 3);
            ram_delay = d;
            w  = int'(a[17:1]);
            do_xfer(is_dma, r, wr, a, wd, rd, lat, st, ak, gl);
            tests_run++;
            if (!r && !wr) begin
                if (lat !== 1 || st !== 0 || ak !== 1) begin
                    fails++; $display("FAIL rand_none %0d: got lat=%0d strobes=%0d acks=%0d, required 1 0 1", i, lat, st, ak);
                end
            end else if (lat !== 3 + d || st !== 2 + d || ak !== 1 || gl !== 0 || last_addr !== 17'(w)) begin
                fails++; $display("FAIL rand_cycle %0d: got lat=%0d strobes=%0d acks=%0d addr=%h, required %0d %0d 1 %h",
                                  i, lat, st, ak, last_addr, 3 + d, 2 + d, 17'(w));
            end
            if (wr) begin
                ref_mem[w] = wd;
                tests_run++;
                if (last_wr !== 1'b1 || last_wdata !== wd) begin
                    fails++; $display("FAIL rand_wr %0d: got wr=%b wdata=%h, required 1 %h", i, last_wr, last_wdata, wd);
                end
            end else if (r) begin
                tests_run++;
                if (rd !== ref_read(w)) begin
                    fails++; $display("FAIL rand_rd %0d: got %h, required %h", i, rd, ref_read(w));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dma_read();
        test_dma_write();
        test_simultaneous();
        test_ram_delay();
        test_contention();
        test_reset_mid();
        test_illegal_and_addr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at 90000 cycles, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
